// File: rtl/uart_rx.sv
// uart_rx: serial frame receiver (start, p_WORD_LEN data bits LSB first, one stop bit)
// with a 2-flop input synchronizer, framing-error reporting and break hold-off.
module uart_rx #(
    parameter int p_CLK_DIV  = 104,
    parameter int p_WORD_LEN = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx,
    output logic [p_WORD_LEN-1:0] o_data,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_active
);
    localparam int CW = $clog2(p_CLK_DIV + 1);
    localparam int BW = $clog2(p_WORD_LEN + 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(p_CLK_DIV / 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(p_CLK_DIV);
    localparam logic [BW-1:0] LAST_BIT = BW'(p_WORD_LEN - 1);

    typedef enum logic [2:0] {
        s_IDLE  = 3'd0,
        s_START = 3'd1,
        s_DATA  = 3'd2,
        s_STOP  = 3'd3,
        s_BREAK = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic                  rx_s;
    logic [CW-1:0]         clk_count_q, clk_count_d;
    logic [BW-1:0]         bit_count_q, bit_count_d;
    logic [p_WORD_LEN-1:0] shift_q, shift_d;
    logic [p_WORD_LEN-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  active_q, active_d;

    assign rx_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_count_d = bit_count_q;
        shift_d     = shift_q;
        data_d      = data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            s_IDLE: begin
                if (!rx_s) begin
                    state_d = s_START;
                end
            end
            s_START: begin
                // Re-check the line half a bit in; a high here was only a glitch.
                if (clk_count_q == HALF_CNT) begin
                    state_d = rx_s ? s_IDLE : s_DATA;
                end else begin
                    clk_count_d = clk_count_q + CW'(1);
                end
            end
            s_DATA: begin
                if (clk_count_q == FULL_CNT) begin
                    for (int i = 0; i < p_WORD_LEN; i++) begin
                        if (bit_count_q == BW'(i)) begin
                            shift_d[i] = rx_s;
                        end
                    end
                    clk_count_d = '0;
                    if (bit_count_q == LAST_BIT) begin
                        state_d = s_STOP;
                    end else begin
                        bit_count_d = bit_count_q + BW'(1);
                    end
                end else begin
                    clk_count_d = clk_count_q + CW'(1);
                end
            end
            s_STOP: begin
                if (clk_count_q == FULL_CNT) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = s_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = s_BREAK;
                    end
                end else begin
                    clk_count_d = clk_count_q + CW'(1);
                end
            end
            s_BREAK: begin
                // Hold off until the line recovers so a long low is not a new start bit.
                if (rx_s) begin
                    state_d = s_IDLE;
                end
            end
            default: begin
                state_d = s_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            clk_count_d = '0;
            bit_count_d = '0;
        end

        active_d = (state_d != s_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= s_IDLE;
            clk_count_q <= '0;
            bit_count_q <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            sync1_q     <= i_rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_count_q <= bit_count_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            active_q    <= active_d;
        end
    end

    assign o_data   = data_q;
    assign o_done   = done_q;
    assign o_err    = err_q;
    assign o_active = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames with a time-based transmitter model and checks
// received words, error pulses, activity flag and latency against expected values.
module tb_uart_rx;
    localparam int CLK_DIV  = 9;
    localparam int WORD_LEN = 8;
    localparam int CLK_T    = 10;
    localparam int BIT_T    = (CLK_DIV + 1) * CLK_T;
    localparam int HALF     = CLK_DIV / 2;
    // Cycle 0 is the first rising edge after the line falls.
    localparam int EXP_LAT  = 3 + HALF + (WORD_LEN + 1) * (CLK_DIV + 1);

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                rx    = 1'b1;
    logic [WORD_LEN-1:0] data;
    logic                done;
    logic                err;
    logic                active;

    int total = 0;
    int bad   = 0;

    logic [WORD_LEN-1:0] got_q[$];
    int                  err_seen    = 0;
    int                  both_seen   = 0;
    int                  active_seen = 0;
    int                  data_glitch = 0;
    logic [WORD_LEN-1:0] prev_data   = '0;
    logic [WORD_LEN-1:0] last_word   = '0;

    // single-frame measurement results
    bit                  seen;
    bit                  act_drop;
    int                  lat;
    logic [WORD_LEN-1:0] d_at;
    logic                a_at;
    logic                e_at;

    always #(CLK_T / 2) clk = ~clk;

    uart_rx #(
        .p_CLK_DIV (CLK_DIV),
        .p_WORD_LEN(WORD_LEN)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_rx    (rx),
        .o_data  (data),
        .o_done  (done),
        .o_err   (err),
        .o_active(active)
    );

    always @(negedge clk) begin
        if (done) got_q.push_back(data);
        if (err) err_seen++;
        if (done && err) both_seen++;
        if (active) active_seen++;
        if (rst_n && !done && data !== prev_data) data_glitch++;
        prev_data = data;
    end

    // Line stays at the stop value when the task returns.
    task automatic send_frame(input logic [WORD_LEN-1:0] w, input int bit_t,
                              input logic stop_bit, input int stop_t);
        rx = 1'b0;
        #(bit_t);
        for (int k = 0; k < WORD_LEN; k++) begin
            rx = w[k];
            #(bit_t);
        end
        rx = stop_bit;
        #(stop_t);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_in_data got=%h want=00", data); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_in_done got=%b want=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_in_err got=%b want=0", err); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_in_active got=%b want=0", active); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", data); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_out_active got=%b want=0", active); end
        total++; if (err_seen + got_q.size() !== 0) begin bad++; $display("FAIL reset_out_pulses got=%0d want=0", err_seen + got_q.size()); end
        $display("reset: released, outputs idle");
    endtask

    task automatic test_single();
        int e0;
        got_q.delete();
        e0 = err_seen;
        seen = 0; act_drop = 0; lat = -1; d_at = '0; a_at = 1'b1; e_at = 1'b1;
        @(negedge clk);
        fork
            send_frame(8'hA5, BIT_T, 1'b1, BIT_T);
            begin
                for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
                    @(negedge clk);
                    if (done) begin
                        seen = 1; lat = cyc - 1; d_at = data; a_at = active; e_at = err;
                    end else if (cyc >= 3 && !active) begin
                        act_drop = 1;
                    end
                end
            end
        join
        #(3 * BIT_T);
        total++; if (!seen) begin bad++; $display("FAIL single_timeout got=no_done want=done"); end
        total++; if (lat != EXP_LAT) begin bad++; $display("FAIL single_latency got=%0d want=%0d", lat, EXP_LAT); end
        total++; if (d_at !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", d_at); end
        total++; if (act_drop) begin bad++; $display("FAIL single_active_during got=0 want=1"); end
        total++; if (a_at !== 1'b0) begin bad++; $display("FAIL single_active_end got=%b want=0", a_at); end
        total++; if (e_at !== 1'b0 || err_seen != e0) begin bad++; $display("FAIL single_err got=%0d want=0", err_seen - e0); end
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", got_q.size()); end
        last_word = 8'hA5;
        $display("single: word a5 latency=%0d", lat);
    endtask

    task automatic test_back_to_back();
        int e0;
        got_q.delete();
        e0 = err_seen;
        @(negedge clk);
        send_frame(8'h00, BIT_T, 1'b1, BIT_T);
        send_frame(8'hFF, BIT_T, 1'b1, BIT_T);
        #(3 * BIT_T);
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", got_q.size()); end
        if (got_q.size() == 2) begin
            total++; if (got_q[0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h want=00", got_q[0]); end
            total++; if (got_q[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h want=ff", got_q[1]); end
        end
        total++; if (err_seen != e0) begin bad++; $display("FAIL b2b_err got=%0d want=0", err_seen - e0); end
        last_word = 8'hFF;
        $display("back_to_back: words 00 ff, %0d received", got_q.size());
    endtask

    task automatic test_glitch();
        int e0, a0;
        got_q.delete();
        e0 = err_seen;
        a0 = active_seen;
        @(negedge clk);
        rx = 1'b0;
        #(3 * CLK_T);
        rx = 1'b1;
        #(3 * BIT_T);
        total++; if (active_seen <= a0) begin bad++; $display("FAIL glitch_active_pulse got=0 want=>0"); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL glitch_active_end got=%b want=0", active); end
        total++; if (got_q.size() != 0 || err_seen != e0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", got_q.size() + err_seen - e0); end
        total++; if (data !== last_word) begin bad++; $display("FAIL glitch_data got=%h want=%h", data, last_word); end
        $display("glitch: 3-cycle low, active cycles=%0d", active_seen - a0);
    endtask

    task automatic test_framing_break();
        int e0;
        got_q.delete();
        e0 = err_seen;
        @(negedge clk);
        send_frame(8'h3C, BIT_T, 1'b0, 50 * CLK_T);
        total++; if (err_seen != e0 + 1) begin bad++; $display("FAIL break_err_count got=%0d want=1", err_seen - e0); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL break_active_hold got=%b want=1", active); end
        rx = 1'b1;
        #(3 * BIT_T);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL break_active_end got=%b want=0", active); end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL break_no_done got=%0d want=0", got_q.size()); end
        total++; if (data !== last_word) begin bad++; $display("FAIL break_data_kept got=%h want=%h", data, last_word); end
        @(negedge clk);
        send_frame(8'h5A, BIT_T, 1'b1, BIT_T);
        #(3 * BIT_T);
        total++; if (got_q.size() != 1 || data !== 8'h5A) begin bad++; $display("FAIL break_next_word got=%h n=%0d want=5a n=1", data, got_q.size()); end
        total++; if (err_seen != e0 + 1) begin bad++; $display("FAIL break_err_total got=%0d want=1", err_seen - e0); end
        last_word = 8'h5A;
        $display("framing_break: 3c with low stop, then 5a");
    endtask

    task automatic test_reset_mid();
        logic [WORD_LEN-1:0] w;
        int e0;
        w = 8'hC3;
        got_q.delete();
        @(negedge clk);
        rx = 1'b0;
        #(BIT_T);
        for (int k = 0; k < 4; k++) begin
            rx = w[k];
            #(BIT_T);
        end
        rx = w[4];
        #(BIT_T / 2 + 3);
        rst_n = 1'b0;
        #1;
        total++; if (data !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%h want=00", data); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_mid_active got=%b want=0", active); end
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_mid_pulses got=%b%b want=00", done, err); end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e0 = err_seen;
        last_word = '0;
        #(3 * BIT_T);
        total++; if (got_q.size() != 0 || err_seen != e0) begin bad++; $display("FAIL rst_mid_no_pulse got=%0d want=0", got_q.size() + err_seen - e0); end
        @(negedge clk);
        send_frame(8'h81, BIT_T, 1'b1, BIT_T);
        #(3 * BIT_T);
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL rst_mid_next_count got=%0d want=1", got_q.size()); end
        total++; if (data !== 8'h81) begin bad++; $display("FAIL rst_mid_next_data got=%h want=81", data); end
        last_word = 8'h81;
        $display("reset_mid: aborted frame, then 81");
    endtask

    task automatic test_baud();
        logic [WORD_LEN-1:0] exp_q[$];
        logic [WORD_LEN-1:0] w;
        int p, g, e0;
        got_q.delete();
        e0 = err_seen;
        // Falling edges placed just before a rising clock edge.
        @(posedge clk); #(CLK_T - 1);
        send_frame(8'h55, 103, 1'b1, 103);
        exp_q.push_back(8'h55);
        #(3 * BIT_T);
        @(posedge clk); #(CLK_T - 1);
        send_frame(8'hAA, 97, 1'b1, 97);
        exp_q.push_back(8'hAA);
        #(3 * BIT_T);
        for (int i = 0; i < 8; i++) begin
            w = WORD_LEN'($urandom_range(0, 255));
            p = $urandom_range(99, 101);
            g = $urandom_range(0, 40);
            @(negedge clk);
            send_frame(w, p, 1'b1, p);
            exp_q.push_back(w);
            $display("baud: tx word=%h period=%0d gap=%0d", w, p, g);
            #(g);
        end
        #(3 * BIT_T);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL baud_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL baud_word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (err_seen != e0) begin bad++; $display("FAIL baud_err got=%0d want=0", err_seen - e0); end
        last_word = exp_q[exp_q.size() - 1];
        total++; if (data !== last_word) begin bad++; $display("FAIL baud_data_hold got=%h want=%h", data, last_word); end
    endtask

    task automatic test_invariants();
        total++; if (both_seen != 0) begin bad++; $display("FAIL done_err_overlap got=%0d want=0", both_seen); end
        total++; if (data_glitch != 0) begin bad++; $display("FAIL data_change_without_done got=%0d want=0", data_glitch); end
        $display("invariants: overlap=%0d stray_data_changes=%0d", both_seen, data_glitch);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing_break();
        test_reset_mid();
        test_baud();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers 8N1-style frames (start bit, p_WORD_LEN data bits LSB first, one stop bit) from the asynchronous serial line and presents each received word with a one-cycle completion pulse. It is the receive-side counterpart of the team's UART transmitter and uses the same bit-period convention, so a receiver and transmitter built with equal p_CLK_DIV interoperate directly. It sits between the chip pin (after the pad) and the byte-level consumer logic.

## Interface
- p_CLK_DIV, 104, bit period minus one; one bit lasts p_CLK_DIV+1 i_clk cycles (must be >= 3)
- p_WORD_LEN, 8, data bits per frame (1..16)
- i_clk  input  1  clock, rising-edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_rx  input  1  serial line, asynchronous to i_clk, idle high
- o_data  output  p_WORD_LEN  last good word; updated only on o_done
- o_done  output  1  one-cycle pulse: new word valid on o_data
- o_err  output  1  one-cycle pulse: framing error (stop bit sampled 0)
- o_active  output  1  high while a frame is being received

## Operation
- Reset (async assert, sync release): state s_IDLE; both synchronizer flops 1; counters 0; shift register 0; o_data=0, o_done=0, o_err=0, o_active=0. Reset mid-frame discards the frame, no pulse.
- i_rx passes through a 2-flop synchronizer; all logic below uses the synchronized value rx_s.
- Counters: r_clk_count width $clog2(p_CLK_DIV+1), r_bit_count width $clog2(p_WORD_LEN+1); both cleared on every state change; no wrap beyond terminal values.
- s_IDLE: o_active=0. rx_s==0 -> s_START, o_active=1.
- s_START: count to h=floor(p_CLK_DIV/2). At r_clk_count==h: rx_s==0 -> s_DATA; rx_s==1 -> false start, s_IDLE, o_active=0, no pulse.
- s_DATA: count to p_CLK_DIV; at terminal count sample rx_s into shift[r_bit_count], increment bit count; after bit p_WORD_LEN-1 sampled -> s_STOP.
- s_STOP: count to p_CLK_DIV; at terminal count sample rx_s:
  - 1: o_data<=shift, o_done=1 next cycle, -> s_IDLE, o_active=0.
  - 0: o_err=1 next cycle, o_data unchanged, -> s_BREAK (o_active stays 1).
- s_BREAK: wait for rx_s==1, then -> s_IDLE, o_active=0. Prevents a held-low line (break) from being re-detected as a start bit.
- o_done and o_err are never both high; each high for exactly one cycle per frame.
- Unused state encodings -> s_IDLE.

## Timing
- Synchronizer latency: 2 cycles from i_rx edge to rx_s.
- Cycle 0 = edge where s_IDLE sees rx_s==0. Start check at cycle h+1 (mid start bit).
- Data bit k sampled at cycle h+1+(k+1)(p_CLK_DIV+1); stop sampled at h+1+(p_WORD_LEN+1)(p_CLK_DIV+1).
- o_done/o_err registered: high the cycle after the stop sample; s_IDLE active the same cycle, so a start bit immediately following a one-bit stop is detected without loss.
- Total i_rx falling edge -> o_done: 3+h+(p_WORD_LEN+1)(p_CLK_DIV+1) cycles.
- Mid-bit sampling tolerates approx +/-4% baud mismatch for p_WORD_LEN=8.
- o_data stable from o_done until the next o_done.

## Test plan
- p_CLK_DIV=9, word 0xA5 framed correctly -> o_done one cycle at cycle 3+4+90=97 after falling edge, o_data=0xA5, o_err=0, o_active high throughout then low.
- Back-to-back 0x00 then 0xFF, stop bit exactly 10 cycles -> two o_done pulses, o_data 0x00 then 0xFF, no o_err.
- Low glitch of 3 cycles on idle line -> o_active pulses, returns to s_IDLE, no o_done/o_err, o_data unchanged.
- 0x3C with stop bit 0, line held low 50 cycles then high -> one o_err pulse, no o_done, o_data keeps previous value, no new start detected until line returns high; next valid 0x5A received correctly.
- i_rst_n asserted during data bit 4 of a frame -> all outputs 0 immediately; after release, next full frame 0x81 received correctly.
- Transmitter period 10.3 and 9.7 cycles/bit (+/-3%), words 0x55/0xAA -> correct o_data, no o_err.
